// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer state encoding and control-word bit layout
// Ports: none (package). Imported by the sequencer, its microcode ROM and the datapath.
package cpu_pkg;
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, HALT} state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit order matches the concatenation used to fan the word out onto the bus signals.
    localparam int CW_W      = 15;
    localparam int B_PC_OE   = 14;
    localparam int B_IR_OE   = 13;
    localparam int B_RAM_OE  = 12;
    localparam int B_ACC_OE  = 11;
    localparam int B_ALU_OE  = 10;
    localparam int B_MAR_WE  = 9;
    localparam int B_IR_WE   = 8;
    localparam int B_RAM_WE  = 7;
    localparam int B_ACC_WE  = 6;
    localparam int B_B_WE    = 5;
    localparam int B_OUT_WE  = 4;
    localparam int B_FLAG_WE = 3;
    localparam int B_PC_LD   = 2;
    localparam int B_PC_INC  = 1;
    localparam int B_ALU_SUB = 0;

    typedef logic [CW_W-1:0] cw_t;

    // Final micro-step of each instruction; HLT leaves T2 for HALT instead.
    function automatic state_t last_step(input logic [3:0] op);
        return (op == OP_LDA || op == OP_STA) ? T3 :
               (op == OP_ADD || op == OP_SUB) ? T4 : T2;
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: sequencer control/status bundle
// Ports: run, opcode, carry, zero into the sequencer; bus-drive enables, load strobes,
// alu_sub, tstate and hlt out of it. master = sequencer side, slave = datapath side.
interface control_sequencer_if;
    logic       run;
    logic [3:0] opcode;
    logic       carry, zero;
    logic       pc_oe, ir_oe, ram_oe, acc_oe, alu_oe;
    logic       mar_we, ir_we, ram_we, acc_we, b_we, out_we, flag_we, pc_ld, pc_inc;
    logic       alu_sub;
    logic [2:0] tstate;
    logic       hlt;

    modport master (
        input  run, opcode, carry, zero,
        output pc_oe, ir_oe, ram_oe, acc_oe, alu_oe,
        output mar_we, ir_we, ram_we, acc_we, b_we, out_we, flag_we, pc_ld, pc_inc,
        output alu_sub, tstate, hlt
    );
    modport slave (
        output run, opcode, carry, zero,
        input  pc_oe, ir_oe, ram_oe, acc_oe, alu_oe,
        input  mar_we, ir_we, ram_we, acc_we, b_we, out_we, flag_we, pc_ld, pc_inc,
        input  alu_sub, tstate, hlt
    );
endinterface

// File: rtl/microcode_rom.sv
// microcode_rom: combinational (state, latched opcode, flags) to control-word decode
// Ports: state, op (latched opcode), carry, zero in; cw (control word) out.
module microcode_rom
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       carry,
    input  logic       zero,
    output cw_t        cw
);
    always_comb begin
        cw = '0;
        case (state)
            T0: begin
                cw[B_PC_OE]  = 1'b1;
                cw[B_MAR_WE] = 1'b1;
            end
            T1: begin
                cw[B_RAM_OE] = 1'b1;
                cw[B_IR_WE]  = 1'b1;
                cw[B_PC_INC] = 1'b1;
            end
            T2: case (op)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    cw[B_IR_OE]  = 1'b1;
                    cw[B_MAR_WE] = 1'b1;
                end
                OP_LDI: begin
                    cw[B_IR_OE]  = 1'b1;
                    cw[B_ACC_WE] = 1'b1;
                end
                OP_JMP, OP_JC, OP_JZ: begin
                    // Conditional jumps read the live flags; an untaken jump drives nothing.
                    cw[B_IR_OE] = op == OP_JMP || (op == OP_JC && carry) || (op == OP_JZ && zero);
                    cw[B_PC_LD] = cw[B_IR_OE];
                end
                OP_OUT: begin
                    cw[B_ACC_OE] = 1'b1;
                    cw[B_OUT_WE] = 1'b1;
                end
                default: cw = '0;
            endcase
            T3: case (op)
                OP_LDA: begin
                    cw[B_RAM_OE] = 1'b1;
                    cw[B_ACC_WE] = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw[B_RAM_OE] = 1'b1;
                    cw[B_B_WE]   = 1'b1;
                end
                OP_STA: begin
                    cw[B_ACC_OE] = 1'b1;
                    cw[B_RAM_WE] = 1'b1;
                end
                default: cw = '0;
            endcase
            T4: begin
                cw[B_ALU_OE]  = 1'b1;
                cw[B_ACC_WE]  = 1'b1;
                cw[B_FLAG_WE] = 1'b1;
                cw[B_ALU_SUB] = op == OP_SUB;
            end
            default: cw = '0;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state micro-sequencer for an 8-bit bus CPU
// Ports: clk, reset (async, active high); bus (master modport) carries run, opcode, flags
// in and the Moore control word, tstate and hlt out.
module control_sequencer
    import cpu_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);
    state_t     state, state_nx;
    logic [3:0] op_q;
    logic       armed;
    logic       adv;
    cw_t        rom_cw, cw;

    // armed stays low for the first running edge after reset so the first fetch starts at T0.
    assign adv = armed && bus.run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T0;
            op_q  <= OP_NOP;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= armed | bus.run;
            if (adv && state == T1) op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_nx = state;
        if (adv) begin
            case (state)
                T0: state_nx = T1;
                T1: state_nx = T2;
                T2, T3, T4: state_nx = (state == T2 && op_q == OP_HLT) ? HALT :
                                       (state == last_step(op_q)) ? T0 : state_t'(state + 3'd1);
                default: state_nx = state;
            endcase
        end
    end

    microcode_rom rom (
        .state (state),
        .op    (op_q),
        .carry (bus.carry),
        .zero  (bus.zero),
        .cw    (rom_cw)
    );

    // HALT decodes to all-zero in the ROM, so only freeze/unarmed gating is needed here.
    assign cw = adv ? rom_cw : '0;

    assign {bus.pc_oe, bus.ir_oe, bus.ram_oe, bus.acc_oe, bus.alu_oe,
            bus.mar_we, bus.ir_we, bus.ram_we, bus.acc_we, bus.b_we, bus.out_we,
            bus.flag_we, bus.pc_ld, bus.pc_inc, bus.alu_sub} = cw;
    assign bus.tstate = (state == HALT) ? 3'd0 : state;
    assign bus.hlt    = state == HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer against a step model
module tb_control_sequencer;
    localparam logic [14:0] PCO = 15'h4000, IRO = 15'h2000, RAMO = 15'h1000, ACCO = 15'h0800;
    localparam logic [14:0] ALUO = 15'h0400, MARW = 15'h0200, IRW = 15'h0100, RAMW = 15'h0080;
    localparam logic [14:0] ACCW = 15'h0040, BW = 15'h0020, OUTW = 15'h0010, FLW = 15'h0008;
    localparam logic [14:0] PCLD = 15'h0004, PCINC = 15'h0002, SUB = 15'h0001;

    logic clk = 0, reset = 0, cmp_en = 0;
    int   checks = 0, errors = 0;
    int   m_step = 0, m_op = 0;
    bit   m_halt = 0, m_armed = 0;

    always #5 clk = ~clk;

    control_sequencer_if bus ();
    control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [14:0] cw_of();
        return {bus.pc_oe, bus.ir_oe, bus.ram_oe, bus.acc_oe, bus.alu_oe, bus.mar_we, bus.ir_we,
                bus.ram_we, bus.acc_we, bus.b_we, bus.out_we, bus.flag_we, bus.pc_ld, bus.pc_inc,
                bus.alu_sub};
    endfunction

    function automatic int ncyc(int op);
        return (op == 1 || op == 4) ? 4 : (op == 2 || op == 3) ? 5 : 3;
    endfunction

    function automatic logic [14:0] exp_cw(int step, int op, bit c, bit z);
        case (step)
            0: return PCO | MARW;
            1: return RAMO | IRW | PCINC;
            2: case (op)
                1, 2, 3, 4: return IRO | MARW;
                5: return IRO | ACCW;
                6: return IRO | PCLD;
                7: return c ? (IRO | PCLD) : 15'h0;
                8: return z ? (IRO | PCLD) : 15'h0;
                14: return ACCO | OUTW;
                default: return 15'h0;
            endcase
            3: return op == 1 ? (RAMO | ACCW) : op == 4 ? (ACCO | RAMW) : (RAMO | BW);
            default: return ALUO | ACCW | FLW | (op == 3 ? SUB : 15'h0);
        endcase
    endfunction

    // Instruction-level model: step index within the current instruction plus latched opcode.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_step = 0; m_op = 0; m_halt = 0; m_armed = 0;
        end else if (!m_armed) begin
            m_armed = bus.run;
        end else if (!m_halt && bus.run) begin
            if (m_step == 1) m_op = int'(bus.opcode);
            if (m_step == 2 && m_op == 15) begin
                m_halt = 1; m_step = 0;
            end else begin
                m_step = (m_step == ncyc(m_op) - 1) ? 0 : m_step + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        if (cmp_en) begin
            e = (reset || !m_armed || m_halt || !bus.run) ? 15'h0 :
                exp_cw(m_step, m_op, bus.carry, bus.zero);
            checks++;
            if (cw_of() !== e || bus.tstate !== 3'(m_step) || bus.hlt !== m_halt) begin
                errors++;
                $display("FAIL model t=%0t: cw=%h tstate=%0d hlt=%b required cw=%h tstate=%0d hlt=%b",
                         $time, cw_of(), bus.tstate, bus.hlt, e, m_step, m_halt);
            end
            checks++;
            if ($countones({bus.pc_oe, bus.ir_oe, bus.ram_oe, bus.acc_oe, bus.alu_oe}) > 1) begin
                errors++;
                $display("FAIL bus_excl t=%0t: oe=%b required at most one set", $time,
                         {bus.pc_oe, bus.ir_oe, bus.ram_oe, bus.acc_oe, bus.alu_oe});
            end
        end
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        bus.run = 0; bus.opcode = 0; bus.carry = 0; bus.zero = 0;
        #1 reset = 1;
        #2 cmp_en = 1;
        chk("reset_cw", 32'(cw_of()), 0);
        chk("reset_hlt", 32'(bus.hlt), 0);
        tick(); tick();
        reset = 0; bus.run = 1; bus.opcode = 4'h1;
        tick(); chk("first_t0", 32'({bus.tstate, cw_of()}), 32'({3'd0, PCO | MARW}));
        tick(); chk("lda_t1", 32'({bus.tstate, cw_of()}), 32'({3'd1, RAMO | IRW | PCINC}));
        tick(); chk("lda_t2", 32'({bus.tstate, cw_of()}), 32'({3'd2, IRO | MARW}));
        tick(); chk("lda_t3", 32'({bus.tstate, cw_of()}), 32'({3'd3, RAMO | ACCW}));
        bus.opcode = 4'h2;
        tick(); chk("lda_end", 32'(bus.tstate), 0);
        tick(); tick(); tick(); chk("add_t3", 32'(cw_of()), 32'(RAMO | BW));
        tick(); chk("add_t4", 32'({bus.tstate, cw_of()}), 32'({3'd4, ALUO | ACCW | FLW}));
        tick(); chk("add_end", 32'(bus.tstate), 0);
        bus.opcode = 4'h8; bus.zero = 1;
        tick(); tick(); chk("jz_taken", 32'(cw_of()), 32'(IRO | PCLD));
        tick(); chk("jz_taken_end", 32'(bus.tstate), 0);
        tick(); tick(); bus.zero = 0; #1;
        chk("jz_not_taken", 32'({bus.tstate, cw_of()}), 32'({3'd2, 15'h0}));
        tick(); chk("jz_nt_end", 32'(bus.tstate), 0);
        bus.opcode = 4'h3;
        tick(); tick(); tick(); chk("sub_t3", 32'(cw_of()), 32'(RAMO | BW));
        bus.run = 0; #1;
        chk("freeze_cw", 32'({bus.tstate, cw_of()}), 32'({3'd3, 15'h0}));
        tick(); tick(); chk("freeze_hold", 32'({bus.tstate, cw_of()}), 32'({3'd3, 15'h0}));
        bus.run = 1; #1;
        chk("resume_t3", 32'(cw_of()), 32'(RAMO | BW));
        tick(); chk("sub_t4", 32'({bus.tstate, cw_of()}), 32'({3'd4, ALUO | ACCW | FLW | SUB}));
        tick(); bus.opcode = 4'h2;
        tick(); tick(); tick(); tick(); chk("add2_t4", 32'(bus.tstate), 4);
        reset = 1; #1;
        chk("async_reset", 32'({bus.tstate, cw_of()}), 32'({3'd0, 15'h0}));
        tick(); reset = 0;
        tick(); chk("rearm_t0", 32'({bus.tstate, cw_of()}), 32'({3'd0, PCO | MARW}));
        bus.opcode = 4'hF;
        tick(); tick(); chk("hlt_t2", 32'({bus.hlt, cw_of()}), 0);
        tick(); chk("halted", 32'({bus.hlt, bus.tstate, cw_of()}), 32'({1'b1, 3'd0, 15'h0}));
        for (int i = 0; i < 10; i++) begin
            bus.run = 1'($urandom); bus.opcode = 4'($urandom);
            tick(); chk("halt_absorb", 32'({bus.hlt, bus.tstate, cw_of()}), 32'({1'b1, 3'd0, 15'h0}));
        end
        reset = 1; #1;
        chk("halt_reset", 32'({bus.hlt, bus.tstate}), 0);
        tick(); reset = 0; bus.run = 1;
        for (int i = 0; i < 4000; i++) begin
            bus.run    = $urandom_range(0, 7) != 0;
            bus.opcode = 4'($urandom);
            bus.carry  = 1'($urandom);
            bus.zero   = 1'($urandom);
            reset      = $urandom_range(0, 299) == 0;
            tick();
        end
        reset = 0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port RUN, input, 1; high lets the sequencer advance, low freezes it.
REQ-004 SHALL have port OPCODE, input, 4, the upper nibble of the instruction register.
REQ-005 SHALL have ports CARRY and ZERO, input, 1 each, the ALU flag register outputs.
REQ-006 SHALL have bus-drive outputs PC_OE, IR_OE, RAM_OE, ACC_OE and ALU_OE, 1 each, enabling drive onto the 8-bit bus.
REQ-007 SHALL have load outputs MAR_WE, IR_WE, RAM_WE, ACC_WE, B_WE, OUT_WE, FLAG_WE, PC_LD and PC_INC, 1 each.
REQ-008 SHALL have output ALU_SUB, 1; high selects A-B and low selects A+B.
REQ-009 SHALL have output TSTATE, 3, the current micro-step number 0 to 4.
REQ-010 SHALL have output HLT, 1, high while the sequencer is in HALT.

Function
REQ-011 SHALL implement the states T0, T1, T2, T3, T4 and HALT.
REQ-012 SHALL drive every control output as a Moore decode of the current state, the latched opcode and the flags; TSTATE SHALL equal the current step.
REQ-013 SHALL use these fetch steps: T0 asserts PC_OE and MAR_WE; T1 asserts RAM_OE, IR_WE and PC_INC.
REQ-014 SHALL latch OPCODE on the rising edge that leaves T1; execution SHALL use only the latched copy.
REQ-015 SHALL execute each opcode, returning to T0 after its last listed step:
  0x0 NOP: T2 drives no controls.
  0x1 LDA: T2 IR_OE+MAR_WE; T3 RAM_OE+ACC_WE.
  0x2 ADD: T2 IR_OE+MAR_WE; T3 RAM_OE+B_WE; T4 ALU_OE+ACC_WE+FLAG_WE.
  0x3 SUB: same as ADD, plus ALU_SUB in T4.
  0x4 STA: T2 IR_OE+MAR_WE; T3 ACC_OE+RAM_WE.
  0x5 LDI: T2 IR_OE+ACC_WE.
  0x6 JMP: T2 IR_OE+PC_LD.
  0x7 JC: T2 IR_OE+PC_LD only if CARRY=1, otherwise no controls.
  0x8 JZ: as JC, qualified by ZERO.
  0xE OUT: T2 ACC_OE+OUT_WE.
  0xF HLT: T2 drives no controls, then the next state is HALT.
  0x9 to 0xD: execute as NOP.
REQ-016 SHALL sample CARRY and ZERO combinationally during T2 of JC and JZ.
REQ-017 SHALL never assert more than one *_OE output in any cycle.
REQ-018 SHALL, while RUN=0, hold the state and latched opcode, and force every control output low except TSTATE and HLT.
REQ-019 SHALL, when RUN rises, resume from the held step with the original control word.
REQ-020 SHALL keep HALT absorbing: all control outputs low, HLT=1, TSTATE=0, and no exit except RESET, whatever RUN is.
REQ-021 SHALL take 3 cycles per instruction for NOP, LDI, JMP, JC, JZ, OUT and HLT; 4 for LDA and STA; 5 for ADD and SUB.

Reset
REQ-022 SHALL, on RESET, immediately and asynchronously force state T0, latched opcode 0x0, TSTATE=0, HLT=0 and all control outputs low.
REQ-023 SHALL make RESET asserted during any step, including HALT, abort the instruction with no further control pulses.
REQ-024 SHALL, on the first rising CLK after RESET falls with RUN=1, stay in T0, so the first fetch begins at T0.

Structure
REQ-025 SHALL place the opcode constants, state encoding and control-word bit indices in a shared package, cpu_pkg, also used by the datapath.
REQ-026 SHALL split the design into one state-register/step-counter process and one sub-module, microcode_rom, a combinational (state, opcode, flags) to control-word decode.

Verification
REQ-027 SHALL cover LDA then ADD: RUN=1, OPCODE=0x1 then 0x2 -> T0..T3 then T0..T4; RAM_OE+ACC_WE in T3 of LDA; ALU_OE+ACC_WE+FLAG_WE with ALU_SUB=0 in T4 of ADD.
REQ-028 SHALL cover JZ both ways: OPCODE=0x8 with ZERO=1 -> PC_LD+IR_OE in T2; with ZERO=0 -> no controls in T2; both return to T0 after T2.
REQ-029 SHALL cover HLT: OPCODE=0xF -> HLT=1 from the cycle after T2; then toggle RUN and OPCODE for 10 cycles -> outputs unchanged; RESET pulse -> T0, HLT=0.
REQ-030 SHALL cover RUN freeze: drop RUN in T3 of SUB -> TSTATE stays 3 with controls low; raise RUN -> T3 controls reappear, then T4 with ALU_SUB=1.
REQ-031 SHALL cover reset mid-instruction: assert RESET between clock edges in T4 of ADD -> outputs low before the next edge, TSTATE=0.
REQ-032 SHALL cover all 16 opcodes with random flags: a bus-exclusivity assertion (at most one *_OE per cycle) never fires.
